dqs_read_detect: RTL and testbench
==================================

Name: dqs_read_detect

Overview:
- Receive-side companion of the DQS transmit path. Consumes 4 deserialized DQS samples per parallel clock (ISERDES output, clk_div domain) after a read is issued.
- Finds the first DQS rising edge after the preamble, measures read latency in parallel-clock cycles, and reports the sample phase.
- Generates the burst data-valid window and checks that DQS toggles correctly for the whole burst.
- Feeds read-leveling / DQ capture alignment logic.

Parameters:
- TIMEOUT, 31: maximum WAIT cycles before the search is abandoned; range 1..2^LAT_WIDTH-1.
- LAT_WIDTH, 5: width of the latency counter and output.
- BURST_CYCLES, 2: parallel cycles of DQS toggling per burst (BL8 with 4:1 deserialization = 2).

Ports:
- clk  in  1  parallel (divided) clock; all logic on the rising edge.
- rst  in  1  asynchronous reset, active high.
- start  in  1  single-cycle pulse: read issued; search begins next cycle.
- dqs_samples  in  4  DQS samples for this cycle; bit0 is earliest in time, bit3 latest.
- busy  out  1  high in WAIT, BURST and DONE.
- data_valid  out  1  high during the BURST_CYCLES cycles following the detection cycle.
- phase  out  2  index p of the first '1' sample at the detected rising edge; held.
- latency  out  LAT_WIDTH  WAIT-cycle count at detection; held.
- done  out  1  one-cycle pulse at the end of a search (success or timeout).
- timeout_err  out  1  no edge found; valid with done, held until next accepted start.
- pattern_err  out  1  toggle mismatch in the burst; valid with done, held until next accepted start.

Behaviour:
- Reset: state=IDLE. busy, data_valid, done, timeout_err and pattern_err are all 0. phase=0, latency=0, prev_bit3=1.
- prev_bit3 register: captures dqs_samples[3] every cycle in every state.
- Edge search, combinational. A rising edge exists in the cycle if either:
  - prev_bit3=0 and bit0=1 (this gives p=0), or
  - bit(i)=0 and bit(i+1)=1 for some i in 0..2 (this gives p=i+1).
  - If several edges exist, the lowest p wins.
- IDLE:
  - start=1 -> go to WAIT, cnt:=1, clear timeout_err and pattern_err.
  - start while not in IDLE is ignored.
- WAIT:
  - Edge found -> latency:=cnt, phase:=p, go to BURST, bcnt:=1.
  - In the detection cycle, bits p..3 must alternate 1,0,1,0 starting at bit p. Any mismatch sets pattern_err.
  - No edge and cnt==TIMEOUT -> timeout_err:=1, go to DONE.
  - Otherwise cnt:=cnt+1.
  - An edge found in the cnt==TIMEOUT cycle counts as a success.
- BURST (data_valid=1):
  - Expected samples: 4'b0101 if p is even, 4'b1010 if p is odd (written MSB..LSB, bit0 = LSB).
  - A mismatch sets pattern_err.
  - bcnt==BURST_CYCLES -> go to DONE; else bcnt:=bcnt+1.
- DONE: done=1 for exactly one cycle, then go to IDLE. start in the DONE cycle is ignored.
- Outputs are registered or decoded from the registered state. Latency from start to done is latency + BURST_CYCLES + 1 cycles; on timeout it is TIMEOUT+1.
- Asynchronous rst in any state returns immediately to the reset values. No done pulse is produced.
- The flags (timeout_err, pattern_err) and the held values (phase, latency) change only in the cycles listed above.

Decomposition:
- Package dqs_rx_pkg:
  - State encoding (IDLE, WAIT, BURST, DONE).
  - Burst pattern constants PAT_EVEN=4'b0101 and PAT_ODD=4'b1010.
  - Sample width constant (4).
- Sub-module dqs_edge_find: purely combinational.
  - Inputs: prev_bit3 and samples.
  - Outputs: found, p, and the partial-cycle alternation-ok flag.
- Top dqs_read_detect holds the FSM, counters and output registers.

Test Plan:
- Aligned edge: start; 3 cycles of 0000; then 0101, 0101, 0101 -> latency=4, phase=0, data_valid for the 2 cycles after detection, done with both errors 0.
- Offset edge: after start, 0000 then 1000 (bit3=1), then 1010, 1010 -> latency=2, phase=3, done, pattern_err=0.
- Timeout: TIMEOUT=5, samples held 0000 -> done 6 cycles after start, timeout_err=1, data_valid never high.
- Glitch: edge 0101 detected, next burst cycle 0111 -> pattern_err=1 at done, latency and phase still reported.
- Boundary:
  - Edge arrives exactly in the cnt==TIMEOUT cycle -> success, latency=TIMEOUT, timeout_err=0.
  - start pulsed during BURST -> ignored.
  - rst asserted mid-BURST -> outputs return to reset values immediately, no done.
- Cross-cycle edge: previous cycle ...0 (bit3=0), current cycle bit0=1 with 0101 -> phase=0.

Source files
------------

// File: rtl/dqs_rx_pkg.sv
// dqs_rx_pkg: shared types and constants for the DQS read-detect receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dqs_rx_pkg;

   // Deserialization ratio: DQS samples delivered per parallel clock.
   localparam int SAMPLE_W = 4;

   // Burst toggle patterns, bit0 earliest in time.
   localparam logic [SAMPLE_W-1:0] PAT_EVEN = 4'b0101;
   localparam logic [SAMPLE_W-1:0] PAT_ODD  = 4'b1010;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_BURST = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/dqs_edge_find.sv
// dqs_edge_find: locates the earliest 0->1 DQS transition in one parallel cycle.
// Latency: purely combinational.
// Backpressure: none.
// Ports: prev_bit3 (latest sample of the previous cycle), samples (bit0 earliest),
//        found (an edge exists), p (sample index of the first '1' at that edge),
//        alt_ok (samples p..3 alternate 1,0,1,0 starting at p).
module dqs_edge_find
   import dqs_rx_pkg::*;
(
   input  logic                prev_bit3,
   input  logic [SAMPLE_W-1:0] samples,
   output logic                found,
   output logic [1:0]          p,
   output logic                alt_ok
);

   logic [SAMPLE_W-1:0] rise;
   logic [SAMPLE_W-1:0] want;
   logic [SAMPLE_W-1:0] mask;

   always_comb begin
      // Each bit compared with its predecessor in time; bit0's predecessor
      // is the last sample of the previous cycle.
      rise  = samples & ~{samples[SAMPLE_W-2:0], prev_bit3};
      found = 1'b0;
      p     = 2'd0;
      // Scan from the latest sample down so the earliest edge wins.
      for (int i = SAMPLE_W - 1; i >= 0; i--) begin
         if (rise[i]) begin
            found = 1'b1;
            p     = 2'(i);
         end
      end
      // Aligning the even pattern at p gives 1,0,1,0 from bit p upward;
      // bits below p are ignored.
      want   = PAT_EVEN << p;
      mask   = {SAMPLE_W{1'b1}} << p;
      alt_ok = ((samples ^ want) & mask) == '0;
   end

endmodule

// File: rtl/dqs_read_detect.sv
// dqs_read_detect: finds the first DQS rising edge after a read, reports latency/phase, checks burst toggling.
// Latency: done pulses latency+BURST_CYCLES+1 cycles after start, or TIMEOUT+1 on timeout.
// Backpressure: none; start outside IDLE is dropped.
// Ports: clk, rst (async, active high), start (read issued pulse), dqs_samples (bit0 earliest),
//        busy, data_valid (burst window), phase/latency (held), done (pulse),
//        timeout_err/pattern_err (held until the next accepted start).
module dqs_read_detect
   import dqs_rx_pkg::*;
#(
   parameter int TIMEOUT      = 31,
   parameter int LAT_WIDTH    = 5,
   parameter int BURST_CYCLES = 2
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [3:0]           dqs_samples,
   output logic                 busy,
   output logic                 data_valid,
   output logic [1:0]           phase,
   output logic [LAT_WIDTH-1:0] latency,
   output logic                 done,
   output logic                 timeout_err,
   output logic                 pattern_err
);

   localparam int BCNT_W = $clog2(BURST_CYCLES + 1);
   localparam logic [LAT_WIDTH-1:0] TIMEOUT_C = LAT_WIDTH'(TIMEOUT);
   localparam logic [BCNT_W-1:0]    BURST_C   = BCNT_W'(BURST_CYCLES);

   state_t               state_q, state_d;
   logic [LAT_WIDTH-1:0] cnt_q, cnt_d;
   logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
   logic [1:0]           phase_q, phase_d;
   logic [LAT_WIDTH-1:0] lat_q, lat_d;
   logic                 terr_q, terr_d;
   logic                 perr_q, perr_d;
   logic                 prev_bit3_q;

   logic                 edge_found;
   logic [1:0]           edge_p;
   logic                 edge_alt_ok;
   logic [3:0]           burst_pat;

   dqs_edge_find u_edge_find (
      .prev_bit3 (prev_bit3_q),
      .samples   (dqs_samples),
      .found     (edge_found),
      .p         (edge_p),
      .alt_ok    (edge_alt_ok)
   );

   // After an edge at phase p the detection cycle ends on bit3 = p[0],
   // so the burst opens on the opposite level.
   assign burst_pat = phase_q[0] ? PAT_ODD : PAT_EVEN;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bcnt_d  = bcnt_q;
      phase_d = phase_q;
      lat_d   = lat_q;
      terr_d  = terr_q;
      perr_d  = perr_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_WAIT;
               cnt_d   = LAT_WIDTH'(1);
               terr_d  = 1'b0;
               perr_d  = 1'b0;
            end
         end
         S_WAIT: begin
            // An edge in the final permitted cycle still counts as success.
            if (edge_found) begin
               lat_d   = cnt_q;
               phase_d = edge_p;
               bcnt_d  = BCNT_W'(1);
               state_d = S_BURST;
               if (!edge_alt_ok) perr_d = 1'b1;
            end else if (cnt_q == TIMEOUT_C) begin
               terr_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + LAT_WIDTH'(1);
            end
         end
         S_BURST: begin
            if (dqs_samples != burst_pat) perr_d = 1'b1;
            if (bcnt_q == BURST_C) state_d = S_DONE;
            else                   bcnt_d  = bcnt_q + BCNT_W'(1);
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bcnt_q      <= '0;
         phase_q     <= '0;
         lat_q       <= '0;
         terr_q      <= 1'b0;
         perr_q      <= 1'b0;
         prev_bit3_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bcnt_q      <= bcnt_d;
         phase_q     <= phase_d;
         lat_q       <= lat_d;
         terr_q      <= terr_d;
         perr_q      <= perr_d;
         prev_bit3_q <= dqs_samples[3];
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign data_valid  = (state_q == S_BURST);
   assign done        = (state_q == S_DONE);
   assign phase       = phase_q;
   assign latency     = lat_q;
   assign timeout_err = terr_q;
   assign pattern_err = perr_q;

endmodule

// File: tb/tb_dqs_read_detect.sv
// tb_dqs_read_detect: directed and randomized checks of dqs_read_detect against a serial-stream model.
// Latency: n/a.
// Backpressure: n/a.
module tb_dqs_read_detect;

   localparam int T  = 5;
   localparam int LW = 5;
   localparam int B  = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [3:0]    dqs_samples;
   logic          busy;
   logic          data_valid;
   logic [1:0]    phase;
   logic [LW-1:0] latency;
   logic          done;
   logic          timeout_err;
   logic          pattern_err;

   dqs_read_detect #(
      .TIMEOUT      (T),
      .LAT_WIDTH    (LW),
      .BURST_CYCLES (B)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dqs_samples (dqs_samples),
      .busy        (busy),
      .data_valid  (data_valid),
      .phase       (phase),
      .latency     (latency),
      .done        (done),
      .timeout_err (timeout_err),
      .pattern_err (pattern_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   // Stimulus: s0 is driven in the start cycle, stim[k-1] in the k-th cycle after it.
   logic [3:0] s0;
   logic [3:0] stim [16];

   // Model results.
   bit m_found;
   int m_c;
   int m_p;
   bit m_perr;
   int last_lat = 0;
   int last_ph  = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Flatten the samples into one serial DQS stream; the edge is the first
   // 0->1 step inside the search window, and from that '1' to the end of the
   // burst the stream must strictly alternate.
   task automatic model_txn();
      bit bits [0:64];
      int qe;
      bit want;
      bits[0] = s0[3];
      for (int c = 0; c < 16; c++)
         for (int i = 0; i < 4; i++)
            bits[1 + 4*c + i] = stim[c][i];
      m_found = 1'b0;
      m_c = 0;
      m_p = 0;
      qe = 0;
      for (int q = 1; q <= 4*T; q++) begin
         if (!m_found && bits[q-1] == 1'b0 && bits[q] == 1'b1) begin
            m_found = 1'b1;
            m_c = (q - 1) / 4 + 1;
            m_p = (q - 1) % 4;
            qe  = q;
         end
      end
      m_perr = 1'b0;
      if (m_found) begin
         for (int q = qe; q <= 4*(m_c + B); q++) begin
            want = ((q - qe) % 2) == 0;
            if (bits[q] != want) m_perr = 1'b1;
         end
      end
   endtask

   task automatic run_txn(input string name, input bit poke_burst, input bit poke_done);
      int done_k;
      int exp_lat;
      int exp_ph;
      model_txn();
      done_k = m_found ? m_c + B + 1 : T + 1;
      start = 1'b1;
      dqs_samples = s0;
      for (int k = 1; k <= done_k + 1; k++) begin
         @(posedge clk); #1;
         start = (poke_burst && m_found && k == m_c + 1) || (poke_done && k == done_k);
         dqs_samples = stim[k-1];
         exp_lat = (m_found && k > m_c) ? m_c : last_lat;
         exp_ph  = (m_found && k > m_c) ? m_p : last_ph;
         check({name, "/busy"}, int'(busy), int'(k <= done_k));
         check({name, "/data_valid"}, int'(data_valid), int'(m_found && k > m_c && k <= m_c + B));
         check({name, "/done"}, int'(done), int'(k == done_k));
         check({name, "/timeout_err"}, int'(timeout_err), int'(!m_found && k >= done_k));
         if (k >= done_k)
            check({name, "/pattern_err"}, int'(pattern_err), int'(m_perr));
         else if (!m_found || k <= m_c)
            check({name, "/pattern_err_clr"}, int'(pattern_err), 0);
         check({name, "/latency"}, int'(latency), exp_lat);
         check({name, "/phase"}, int'(phase), exp_ph);
      end
      start = 1'b0;
      if (m_found) begin
         last_lat = m_c;
         last_ph  = m_p;
      end
   endtask

   task automatic gen_random();
      int mode;
      int c;
      int p;
      int cyc;
      int bitn;
      logic [3:0] pe;
      logic [3:0] po;
      mode = $urandom_range(0, 3);
      for (int i = 0; i < 16; i++) stim[i] = 4'($urandom_range(0, 15));
      s0 = 4'($urandom_range(0, 15));
      if (mode == 2) begin
         pe = ($urandom_range(0, 1) == 1) ? 4'hF : 4'h0;
         s0 = pe;
         for (int i = 0; i < 16; i++) stim[i] = pe;
      end else if (mode != 0) begin
         c = (mode == 3) ? T : $urandom_range(1, T);
         p = $urandom_range(0, 3);
         s0 = 4'h0;
         for (int i = 0; i < c - 1; i++) stim[i] = 4'h0;
         pe = 4'b0101;
         stim[c-1] = pe << p;
         po = ((p % 2) == 1) ? 4'b1010 : 4'b0101;
         for (int i = c; i < c + B; i++) stim[i] = po;
         if ($urandom_range(0, 1) == 1) begin
            cyc  = $urandom_range(c - 1, c + B - 1);
            bitn = $urandom_range(0, 3);
            stim[cyc][bitn] = ~stim[cyc][bitn];
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      dqs_samples = 4'h0;
      s0 = 4'h0;
      stim = '{default: 4'h0};
      #12;
      check("reset/busy", int'(busy), 0);
      check("reset/data_valid", int'(data_valid), 0);
      check("reset/done", int'(done), 0);
      check("reset/phase", int'(phase), 0);
      check("reset/latency", int'(latency), 0);
      check("reset/timeout_err", int'(timeout_err), 0);
      check("reset/pattern_err", int'(pattern_err), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Aligned edge: latency 4, phase 0.
      s0 = 4'h0; stim = '{default: 4'h0};
      stim[3] = 4'b0101; stim[4] = 4'b0101; stim[5] = 4'b0101;
      run_txn("aligned", 1'b0, 1'b0);
      check("aligned/model_lat", last_lat, 4);

      // Offset edge on the last sample: latency 2, phase 3.
      s0 = 4'h0; stim = '{default: 4'h0};
      stim[1] = 4'b1000; stim[2] = 4'b1010; stim[3] = 4'b1010;
      run_txn("offset", 1'b0, 1'b0);

      // Timeout with DQS held low.
      s0 = 4'h0; stim = '{default: 4'h0};
      run_txn("timeout", 1'b0, 1'b0);

      // Glitch in the burst.
      s0 = 4'h0; stim = '{default: 4'h0};
      stim[1] = 4'b0101; stim[2] = 4'b0111; stim[3] = 4'b0101;
      run_txn("glitch", 1'b0, 1'b0);

      // Edge in the final permitted search cycle.
      s0 = 4'h0; stim = '{default: 4'h0};
      stim[T-1] = 4'b0101; stim[T] = 4'b0101; stim[T+1] = 4'b0101;
      run_txn("edge_at_timeout", 1'b0, 1'b0);

      // start during BURST and in DONE must be ignored.
      s0 = 4'h0; stim = '{default: 4'h0};
      stim[2] = 4'b0100; stim[3] = 4'b1010; stim[4] = 4'b1010;
      run_txn("start_ignored", 1'b1, 1'b1);

      // Edge across the cycle boundary; also has a later in-cycle edge.
      s0 = 4'hF; stim = '{default: 4'h0};
      stim[0] = 4'b0000; stim[1] = 4'b0101; stim[2] = 4'b0101; stim[3] = 4'b0101;
      run_txn("cross_cycle", 1'b0, 1'b0);

      // Previous sample high: no edge at bit0, in-cycle edge with bad alternation.
      s0 = 4'hF; stim = '{default: 4'h0};
      stim[0] = 4'b1101; stim[1] = 4'b0101; stim[2] = 4'b0101;
      run_txn("no_cross", 1'b0, 1'b0);

      // Reset in the middle of a burst.
      start = 1'b1; dqs_samples = 4'h0;
      @(posedge clk); #1; start = 1'b0; dqs_samples = 4'h0;
      @(posedge clk); #1; dqs_samples = 4'b0101;
      @(posedge clk); #1; dqs_samples = 4'b0101;
      check("rst_mid/pre_data_valid", int'(data_valid), 1);
      #2 rst = 1'b1;
      #1;
      check("rst_mid/busy", int'(busy), 0);
      check("rst_mid/data_valid", int'(data_valid), 0);
      check("rst_mid/done", int'(done), 0);
      check("rst_mid/phase", int'(phase), 0);
      check("rst_mid/latency", int'(latency), 0);
      check("rst_mid/timeout_err", int'(timeout_err), 0);
      check("rst_mid/pattern_err", int'(pattern_err), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         check("rst_mid/no_done", int'(done), 0);
         check("rst_mid/idle", int'(busy), 0);
      end
      last_lat = 0;
      last_ph  = 0;

      for (int n = 0; n < 60; n++) begin
         gen_random();
         run_txn($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
